// File: rtl/seg_display_reader_if.sv
// Bus bundle between a digit-code source and the four-digit seven-segment scanner.
// The scanner takes the slave side; whoever supplies digit codes takes the master side.
interface seg_display_reader_if;
  logic [4:0] seg0wr;
  logic [4:0] seg1wr;
  logic [4:0] seg2wr;
  logic [4:0] seg3wr;
  logic [3:0] an;
  logic [6:0] cat;
  logic       frame_start;

  modport master (
    output seg0wr, seg1wr, seg2wr, seg3wr,
    input  an, cat, frame_start
  );

  modport slave (
    input  seg0wr, seg1wr, seg2wr, seg3wr,
    output an, cat, frame_start
  );
endinterface

// File: rtl/seg_display_reader.sv
// Time-multiplexed four-digit seven-segment driver with per-slot dead time.
// Digit codes are snapshotted once per frame, so a frame never mixes old and new codes.
module seg_display_reader #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  seg_display_reader_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic [1:0]    dig_r;
  logic [4:0]    snap_r [4];
  logic [3:0]    an_r;
  logic [6:0]    cat_r;
  logic          frame_start_r;

  logic          cnt_wrap_s;
  logic          capture_s;
  logic          dead_s;
  logic [4:0]    cur_code_s;
  logic [3:0]    an_s;
  logic [6:0]    cat_s;

  // Active-low segment pattern for a digit code; any code with bit 4 set is blank.
  function automatic logic [6:0] hex_to_cat(input logic [4:0] code);
    logic [6:0] pat;
    if (code[4]) begin
      pat = 7'b1111111;
    end else begin
      case (code[3:0])
        4'h0:    pat = 7'b1000000;
        4'h1:    pat = 7'b1111001;
        4'h2:    pat = 7'b0100100;
        4'h3:    pat = 7'b0110000;
        4'h4:    pat = 7'b0011001;
        4'h5:    pat = 7'b0010010;
        4'h6:    pat = 7'b0000010;
        4'h7:    pat = 7'b1111000;
        4'h8:    pat = 7'b0000000;
        4'h9:    pat = 7'b0010000;
        4'hA:    pat = 7'b0001000;
        4'hB:    pat = 7'b0000011;
        4'hC:    pat = 7'b1000110;
        4'hD:    pat = 7'b0100001;
        4'hE:    pat = 7'b0000110;
        4'hF:    pat = 7'b0001110;
        default: pat = 7'b1111111;
      endcase
    end
    return pat;
  endfunction

  // A zero dead time would make the comparison constant, so it is elaborated away.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_dead
      assign dead_s = 1'b0;
    end else begin : g_dead
      assign dead_s = (cnt_r < CW'(BLANK_CYCLES));
    end
  endgenerate

  assign cnt_wrap_s = (cnt_r == CW'(REFRESH_DIV - 1));
  assign capture_s  = (cnt_r == CW'(0)) && (dig_r == 2'd0);
  assign cur_code_s = snap_r[dig_r];

  // Next anode/cathode pattern from the current slot position and snapshot.
  always_comb begin
    an_s  = 4'b1111;
    cat_s = 7'b1111111;
    if (!dead_s) begin
      an_s  = ~(4'b0001 << dig_r);
      cat_s = hex_to_cat(cur_code_s);
    end else begin
      an_s  = 4'b1111;
      cat_s = 7'b1111111;
    end
  end

  // Slot counter and digit index; the digit advances each time the slot wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CW'(0);
      dig_r <= 2'd0;
    end else begin
      if (cnt_wrap_s) begin
        cnt_r <= CW'(0);
        dig_r <= dig_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Input snapshot, refreshed only at the very start of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        snap_r[i] <= 5'b11111;
      end
    end else if (capture_s) begin
      snap_r[0] <= bus.seg0wr;
      snap_r[1] <= bus.seg1wr;
      snap_r[2] <= bus.seg2wr;
      snap_r[3] <= bus.seg3wr;
    end
  end

  // Registered outputs; reset drops every anode in the same edge it is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r          <= 4'b1111;
      cat_r         <= 7'b1111111;
      frame_start_r <= 1'b0;
    end else begin
      an_r          <= an_s;
      cat_r         <= cat_s;
      frame_start_r <= capture_s;
    end
  end

  assign bus.an          = an_r;
  assign bus.cat         = cat_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader with REFRESH_DIV=8, BLANK_CYCLES=2.
// Every frame is checked cycle by cycle against hand-written segment patterns.
module tb_seg_display_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg_display_reader_if sif ();

  seg_display_reader #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 32-cycle frame starting with the capture edge; optionally rewrites seg3wr mid-frame.
  task automatic run_frame(input logic [6:0] ec0, input logic [6:0] ec1,
                           input logic [6:0] ec2, input logic [6:0] ec3,
                           input int chg_at, input logic [4:0] chg_val);
    logic [6:0] ec [4];
    ec[0] = ec0;
    ec[1] = ec1;
    ec[2] = ec2;
    ec[3] = ec3;
    for (int i = 0; i < 32; i++) begin
      int d;
      int c;
      logic [3:0] exp_an;
      logic [6:0] exp_cat;
      tick();
      if (i == chg_at) sif.seg3wr = chg_val;
      d = i / 8;
      c = i % 8;
      exp_an  = (c < 2) ? 4'b1111 : ~(4'b0001 << d);
      exp_cat = (c < 2) ? 7'b1111111 : ec[d];
      check_val($sformatf("an d%0d c%0d", d, c), 32'(sif.an), 32'(exp_an));
      check_val($sformatf("cat d%0d c%0d", d, c), 32'(sif.cat), 32'(exp_cat));
      check_val($sformatf("frame_start i%0d", i), 32'(sif.frame_start), (i == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    sif.seg0wr = 5'b00001;
    sif.seg1wr = 5'b00001;
    sif.seg2wr = 5'b00001;
    sif.seg3wr = 5'b00001;
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst an", 32'(sif.an), 32'h0000000F);
      check_val("rst cat", 32'(sif.cat), 32'h0000007F);
      check_val("rst frame_start", 32'(sif.frame_start), 32'd0);
    end

    // Scan order and timing, two consecutive frames.
    sif.seg0wr = 5'h01;
    sif.seg1wr = 5'h02;
    sif.seg2wr = 5'h03;
    sif.seg3wr = 5'h04;
    rst = 1'b0;
    run_frame(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, -1, 5'h00);
    run_frame(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, -1, 5'h00);

    // Blank code on digit 2 keeps its anode on with all segments off.
    sif.seg2wr = 5'b10101;
    run_frame(7'b1111001, 7'b0100100, 7'b1111111, 7'b0011001, -1, 5'h00);

    // seg3wr changes while digit 1 is lit; only the following frame shows it.
    run_frame(7'b1111001, 7'b0100100, 7'b1111111, 7'b0011001, 10, 5'h0F);
    run_frame(7'b1111001, 7'b0100100, 7'b1111111, 7'b0001110, -1, 5'h00);

    // Reset in the middle of the digit-2 active period.
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    check_val("pre-rst an", 32'(sif.an), 32'h0000000B);
    rst = 1'b1;
    tick();
    check_val("midrst an", 32'(sif.an), 32'h0000000F);
    check_val("midrst cat", 32'(sif.cat), 32'h0000007F);
    check_val("midrst frame_start", 32'(sif.frame_start), 32'd0);
    rst = 1'b0;
    run_frame(7'b1111001, 7'b0100100, 7'b1111111, 7'b0001110, -1, 5'h00);

    // Full decode sweep on the rightmost digit, other digits blank.
    sif.seg1wr = 5'h10;
    sif.seg2wr = 5'h1F;
    sif.seg3wr = 5'h10;
    for (int v = 0; v < 16; v++) begin
      sif.seg0wr = {1'b0, 4'(v)};
      run_frame(hex_tbl[v], 7'b1111111, 7'b1111111, 7'b1111111, -1, 5'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
